ahb_lite_cmd_master: RTL and testbench

AHB-Lite initiator that turns single read/write commands from a valid/ready command port into AHB-Lite single transfers toward the user project's AHB slave port, and returns read data or status on a valid/ready response port. It drives the user project's AHB slave port in block-level benches and in the on-chip debug path. At most one transfer is outstanding at a time. A stalled slave is bounded by a wait-state timeout.

---
 rtl/ahb_lite_pkg.sv | 18 +
 rtl/ahb_lite_cmd_master.sv | 157 +++++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite encodings and master state type
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } master_state_e;

endpackage

// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - single-outstanding AHB-Lite initiator driven by a command/response port
module ahb_lite_cmd_master
   import ahb_lite_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [2:0]  cmd_size,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        HSEL,
   output logic        HWRITE,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic        HREADYOUT
);

   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   master_state_e state_q;
   logic          cmd_ready_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic          rsp_timeout_q;
   logic [31:0]   rsp_rdata_q;
   logic          hsel_q;
   logic          data_q;
   logic          hwrite_q;
   logic [31:0]   haddr_q;
   logic [31:0]   hwdata_q;
   logic [31:0]   wdata_q;
   logic [2:0]    hsize_q;
   logic [15:0]   wait_cnt_q;
   logic [15:0]   wait_cnt_d;
   logic          cmd_illegal;

   // Reject sizes above a word and addresses not aligned to the transfer size
   always_comb begin
      cmd_illegal = (cmd_size > HSIZE_WORD)
                 || ((cmd_size == HSIZE_HALF) && cmd_addr[0])
                 || ((cmd_size == HSIZE_WORD) && (cmd_addr[1:0] != 2'b00));
   end

   // Saturating next value of the wait-state counter
   always_comb begin
      wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
   end

   // Transfer FSM; every output except HREADY comes straight from a register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= 32'd0;
         hsel_q        <= 1'b0;
         data_q        <= 1'b0;
         hwrite_q      <= 1'b0;
         haddr_q       <= 32'd0;
         hwdata_q      <= 32'd0;
         wdata_q       <= 32'd0;
         hsize_q       <= HSIZE_WORD;
         wait_cnt_q    <= 16'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  if (cmd_illegal) begin
                     state_q       <= ST_RESP;
                     rsp_valid_q   <= 1'b1;
                     rsp_err_q     <= 1'b1;
                     rsp_timeout_q <= 1'b0;
                     rsp_rdata_q   <= 32'd0;
                  end else begin
                     state_q    <= ST_ADDR;
                     hsel_q     <= 1'b1;
                     haddr_q    <= cmd_addr;
                     hwrite_q   <= cmd_write;
                     hsize_q    <= cmd_size;
                     wdata_q    <= cmd_wdata;
                     wait_cnt_q <= 16'd0;
                  end
               end
            end
            ST_ADDR: begin
               state_q  <= ST_DATA;
               hsel_q   <= 1'b0;
               data_q   <= 1'b1;
               hwdata_q <= wdata_q;
            end
            ST_DATA: begin
               if (HREADYOUT) begin
                  state_q       <= ST_RESP;
                  data_q        <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= hwrite_q ? 32'd0 : HRDATA;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
                  if (wait_cnt_d >= TIMEOUT_LIM) begin
                     state_q       <= ST_RESP;
                     data_q        <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_err_q     <= 1'b0;
                     rsp_timeout_q <= 1'b1;
                     rsp_rdata_q   <= 32'd0;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q       <= ST_IDLE;
                  cmd_ready_q   <= 1'b1;
                  rsp_valid_q   <= 1'b0;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= 32'd0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign HSEL        = hsel_q;
   assign HTRANS      = hsel_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HWRITE      = hwrite_q;
   assign HADDR       = haddr_q;
   assign HWDATA      = hwdata_q;
   assign HSIZE       = hsize_q;
   // The slave's own ready is only looped back while its data phase is open
   assign HREADY      = data_q ? HREADYOUT : 1'b1;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb/tb_ahb_lite_cmd_master.sv - randomized self-checking bench for ahb_lite_cmd_master
module tb_ahb_lite_cmd_master;

   localparam int TO = 4;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        HSEL, HWRITE, HREADY, HREADYOUT;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        err;
      logic        tmo;
      logic [31:0] rdata;
      int          lat;
   } rsp_t;

   ahb_lite_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .HSEL(HSEL), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Expected response and the number of cycles between accept and RESP
   function automatic rsp_t ref_model(input logic wr, input logic [31:0] addr,
                                      input logic [2:0] size, input int waits,
                                      input logic [31:0] sdata);
      rsp_t r;
      if (size > 3'd2) r.err = 1'b1;
      else             r.err = (addr % (32'd1 << size)) != 0;
      r.tmo   = !r.err && (waits >= TO);
      r.rdata = (!r.err && !r.tmo && !wr) ? sdata : 32'd0;
      if (r.err)      r.lat = 0;
      else if (r.tmo) r.lat = 1 + TO;
      else            r.lat = 2 + waits;
      return r;
   endfunction

   task automatic chk_reset(input string t);
      chk({t, "_cmd_ready"},   cmd_ready,   1);
      chk({t, "_rsp_valid"},   rsp_valid,   0);
      chk({t, "_rsp_err"},     rsp_err,     0);
      chk({t, "_rsp_timeout"}, rsp_timeout, 0);
      chk({t, "_rsp_rdata"},   rsp_rdata,   0);
      chk({t, "_hsel"},        HSEL,        0);
      chk({t, "_htrans"},      HTRANS,      0);
      chk({t, "_haddr"},       HADDR,       0);
      chk({t, "_hwdata"},      HWDATA,      0);
      chk({t, "_hwrite"},      HWRITE,      0);
      chk({t, "_hsize"},       HSIZE,       2);
      chk({t, "_hready"},      HREADY,      1);
   endtask

   // Called just after a rising edge; returns just after a rising edge
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input int waits, input logic [31:0] sdata,
                          input int hold);
      rsp_t e;
      e = ref_model(wr, addr, size, waits, sdata);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_size  = size;
      @(negedge HCLK);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge HCLK);
      #1;
      cmd_valid = 1'b0;
      cmd_wdata = $urandom;
      cmd_addr  = $urandom;
      for (int c = 0; c < e.lat; c++) begin
         if (c == 0) begin
            HREADYOUT = 1'b1;
         end else begin
            HREADYOUT = (c - 1 == waits);
            HRDATA    = (c - 1 == waits) ? sdata : $urandom;
         end
         @(negedge HCLK);
         chk("rsp_valid_early", rsp_valid, 0);
         chk("cmd_ready_busy", cmd_ready, 0);
         if (c == 0) begin
            chk("addr_hsel",   HSEL,   1);
            chk("addr_htrans", HTRANS, 2);
            chk("addr_haddr",  HADDR,  addr);
            chk("addr_hwrite", HWRITE, wr);
            chk("addr_hsize",  HSIZE,  size);
            chk("addr_hready", HREADY, 1);
         end else begin
            chk("data_hsel",   HSEL,   0);
            chk("data_htrans", HTRANS, 0);
            chk("data_hwdata", HWDATA, wdata);
            chk("data_haddr",  HADDR,  addr);
            chk("data_hready", HREADY, HREADYOUT);
         end
         @(posedge HCLK);
         #1;
      end
      HREADYOUT = 1'b1;
      HRDATA    = $urandom;
      for (int d = 0; d <= hold; d++) begin
         rsp_ready = (d == hold);
         @(negedge HCLK);
         chk("rsp_valid",   rsp_valid,   1);
         chk("rsp_err",     rsp_err,     e.err);
         chk("rsp_timeout", rsp_timeout, e.tmo);
         chk("rsp_rdata",   rsp_rdata,   e.rdata);
         chk("resp_cmd_ready", cmd_ready, 0);
         chk("resp_hsel",   HSEL,   0);
         chk("resp_htrans", HTRANS, 0);
         chk("resp_hready", HREADY, 1);
         @(posedge HCLK);
         #1;
      end
      rsp_ready = 1'b0;
      @(negedge HCLK);
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_cmd_ready", cmd_ready, 1);
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  s;
      HRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'd0;
      cmd_wdata = 32'd0;
      cmd_size  = 3'd0;
      rsp_ready = 1'b0;
      HRDATA    = 32'd0;
      HREADYOUT = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      chk_reset("reset");
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      // Directed cases
      run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 3'd2, 0, 32'd0, 0);
      run_cmd(1'b0, 32'h3000_0008, 32'h0, 3'd2, 3, 32'hDEAD_0001, 0);
      run_cmd(1'b1, 32'h3000_0002, 32'h1111_1111, 3'd2, 0, 32'd0, 0);
      run_cmd(1'b0, 32'h3000_0001, 32'h0, 3'd1, 0, 32'd0, 0);
      run_cmd(1'b0, 32'h3000_0000, 32'h0, 3'd3, 0, 32'd0, 0);
      run_cmd(1'b0, 32'h3000_000C, 32'h0, 3'd2, 1000, 32'hBEEF_BEEF, 0);
      run_cmd(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 3'd2, 1, 32'd0, 10);
      run_cmd(1'b0, 32'h3000_0013, 32'h0, 3'd0, 0, 32'h0000_005A, 2);

      // Reset in the middle of a stalled data phase
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h3000_0020;
      cmd_wdata = 32'h7777_8888;
      cmd_size  = 3'd2;
      @(posedge HCLK);
      #1;
      cmd_valid = 1'b0;
      HREADYOUT = 1'b0;
      @(posedge HCLK);
      @(posedge HCLK);
      #3;
      chk("mid_data_hready", HREADY, 0);
      HRESETn = 1'b0;
      #1;
      chk_reset("async_reset");
      @(negedge HCLK);
      HRESETn   = 1'b1;
      HREADYOUT = 1'b1;
      @(posedge HCLK);
      #1;
      run_cmd(1'b0, 32'h3000_0024, 32'h0, 3'd2, 2, 32'h1234_5678, 0);

      // Randomized commands
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
         s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         run_cmd(1'($urandom), a, $urandom, s, $urandom_range(0, 5), $urandom,
                 $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
